regfile_wb_sched: RTL

Writeback scheduler and scoreboard for the 32x32 register file. It shares the file's single write port (rw/wrdata/regwr) between two writeback sources: A (ALU/CSR) and B (load unit), using round-robin valid/ready arbitration. It also keeps a per-register busy scoreboard and asserts stall for decode when an issuing instruction reads or targets a register with a pending write. It sits between decode/execute/memory and the regfile, and drives the regfile write port directly.

---
 rtl/regfile_wb_sched_pkg.sv | 12 +
 rtl/regfile_wb_sched_if.sv | 24 ++
 rtl/wb_rr_arb2.sv | 41 ++++
 rtl/regfile_wb_sched.sv | 94 +++++++++
 4 files changed

// File: rtl/regfile_wb_sched_pkg.sv
// Shared constants and source-select encoding for the writeback scheduler.
// The register file has 32 registers of 32 bits, and x0 is hardwired to zero.
package regfile_wb_sched_pkg;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;
endpackage

// File: rtl/regfile_wb_sched_if.sv
// Writeback bus with two sources: A (ALU/CSR) and B (load unit).
// The master modport is the producer side; the slave modport is the scheduler side.
interface regfile_wb_sched_if;
  import regfile_wb_sched_pkg::*;

  logic          aval;
  logic [AW-1:0] ard;
  logic [DW-1:0] adata;
  logic          ardy;
  logic          bval;
  logic [AW-1:0] brd;
  logic [DW-1:0] bdata;
  logic          brdy;

  modport master (
    output aval, ard, adata, bval, brd, bdata,
    input  ardy, brdy
  );

  modport slave (
    input  aval, ard, adata, bval, brd, bdata,
    output ardy, brdy
  );
endinterface

// File: rtl/wb_rr_arb2.sv
// Two-input round-robin arbiter that grants at most one source per cycle.
// After each grant, priority moves to the other source.
module wb_rr_arb2
  import regfile_wb_sched_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic aval,
  input  logic bval,
  output logic ardy,
  output logic brdy,
  output src_e sel
);

  src_e ptr_q, ptr_d;

  // Grants depend only on the valids and on ptr, never on the readys.
  always_comb begin
    ardy  = 1'b0;
    brdy  = 1'b0;
    sel   = SRC_A;
    ptr_d = ptr_q;
    if (rstn) begin
      if (aval && (!bval || ptr_q == SRC_A)) begin
        ardy  = 1'b1;
        sel   = SRC_A;
        ptr_d = SRC_B;
      end else if (bval) begin
        brdy  = 1'b1;
        sel   = SRC_B;
        ptr_d = SRC_A;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) ptr_q <= SRC_A;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler and busy scoreboard in front of the regfile's single write port.
// Arbitrates sources A and B onto the write port and stalls decode on RAW and WAW hazards.
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              isval,
  input  logic [AW-1:0]     isrd,
  input  logic              iswr,
  input  logic [AW-1:0]     isrs1,
  input  logic [AW-1:0]     isrs2,
  output logic              stall,
  regfile_wb_sched_if.slave wb,
  output logic [AW-1:0]     rw,
  output logic [DW-1:0]     wrdata,
  output logic              regwr,
  output logic [NREG-1:0]   busy,
  output logic              err
);

  src_e            sel;
  logic            accept;
  logic            issue_acc;
  logic [AW-1:0]   acc_rd;
  logic [DW-1:0]   acc_data;

  logic            regwr_q, regwr_d;
  logic [AW-1:0]   rw_q, rw_d;
  logic [DW-1:0]   wrdata_q, wrdata_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            err_q, err_d;

  wb_rr_arb2 u_arb (
    .clk  (clk),
    .rstn (rstn),
    .aval (wb.aval),
    .bval (wb.bval),
    .ardy (wb.ardy),
    .brdy (wb.brdy),
    .sel  (sel)
  );

  // A pending clear still reads busy, so there is no same-cycle bypass.
  assign stall = !rstn |
                 (isval & ((busy_q[isrs1] & (isrs1 != '0)) |
                           (busy_q[isrs2] & (isrs2 != '0)) |
                           (iswr & busy_q[isrd] & (isrd != '0))));

  assign issue_acc = isval & !stall;
  assign accept    = wb.ardy | wb.brdy;
  assign acc_rd    = (sel == SRC_B) ? wb.brd   : wb.ard;
  assign acc_data  = (sel == SRC_B) ? wb.bdata : wb.adata;

  always_comb begin
    regwr_d  = 1'b0;
    rw_d     = rw_q;
    wrdata_d = wrdata_q;
    busy_d   = busy_q;
    err_d    = err_q;
    if (accept) begin
      regwr_d  = (acc_rd != '0);
      rw_d     = acc_rd;
      wrdata_d = acc_data;
      if (acc_rd != '0 && !busy_q[acc_rd]) err_d = 1'b1;
    end
    // The clear is applied first; a set of a pending register is impossible because such an issue stalls.
    if (regwr_q) busy_d[rw_q] = 1'b0;
    if (issue_acc && iswr && isrd != '0) busy_d[isrd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      regwr_q  <= 1'b0;
      rw_q     <= '0;
      wrdata_q <= '0;
      busy_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      regwr_q  <= regwr_d;
      rw_q     <= rw_d;
      wrdata_q <= wrdata_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign regwr  = regwr_q;
  assign rw     = rw_q;
  assign wrdata = wrdata_q;
  assign busy   = busy_q;
  assign err    = err_q;

endmodule
